boot_loader: RTL and testbench

- Serial boot sequencer for the instruction memory.
- After reset it holds the CPU, takes a framed program image from the RS232 receiver, and writes it word by word into the instruction-memory write port.
- On a valid checksum it releases the CPU, and the CPU then owns the UART and IM.
- Sits in the top level between rs232, ramx port A and the PC reset path.

---
 rtl/boot_pkg.sv | 30 +++
 rtl/boot_assembler.sv | 60 ++++++
 rtl/boot_loader.sv | 193 +++++++++++++++++++
 tb/tb_boot_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// ============================================================================
// Module : boot_pkg
// Brief  : Shared state encoding and constants for the serial boot loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    RUN    = 3'd5,
    ERROR  = 3'd6
  } boot_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         DATA_W_DEFAULT    = 32;
  localparam int         BYTES_PER_WORD    = DATA_W_DEFAULT / 8;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/boot_assembler.sv
// ============================================================================
// Module : boot_assembler
// Brief  : Byte-to-word shift register with byte index and running XOR sum.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_assembler
  import boot_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        byte_i,
  input  logic              valid_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] word_o,
  output logic              wordValid_o,
  output logic [7:0]        sum_o
);

  localparam int BPW   = bytes_per_word(int'(DATA_W));
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        sum_q;
  logic              wordValid_q;

  // Bytes arrive MSB first, so each new byte shifts in at the bottom.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q      <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      wordValid_q <= 1'b0;
    end else begin
      wordValid_q <= 1'b0;
      if (clear_i) begin
        word_q <= '0;
        idx_q  <= '0;
        sum_q  <= '0;
      end else if (valid_i) begin
        word_q      <= (word_q << 8) | DATA_W'(byte_i);
        sum_q       <= sum_q ^ byte_i;
        wordValid_q <= (idx_q == LAST_IDX);
        idx_q       <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  assign word_o      = word_q;
  assign wordValid_o = wordValid_q;
  assign sum_o       = sum_q;

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// ============================================================================
// Module : boot_loader
// Brief  : Holds the CPU, loads a framed image from RS232 into IM, then
//          releases it. Optional idle/stall timeout under BOOT_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BASE_ADDR      = 0,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 40000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              charReady,
  input  logic [7:0]        RXchar,
  output logic              readRX,
  output logic              imWe,
  output logic [ADDR_W-1:0] imAddr,
  output logic [DATA_W-1:0] imData,
  output logic              cpuHold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_W;

  boot_state_e       state_q;
  logic              readRX_q;
  logic              readRX_d;
  logic              cpuHold_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] imAddr_q;
  logic [7:0]        cntHi_q;
  logic [15:0]       words_q;

  logic [15:0]       w_count;
  logic [DATA_W-1:0] w_word;
  logic              w_wordValid;
  logic [7:0]        w_sum;
  logic              w_tmo;

  assign w_count = {cntHi_q, RXchar};

  boot_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clock       (clock),
    .reset_n     (reset_n),
    .byte_i      (RXchar),
    .valid_i     (readRX_q && (state_q == DATA)),
    .clear_i     (readRX_q && (state_q == CNT_LO)),
    .word_o      (w_word),
    .wordValid_o (w_wordValid),
    .sum_o       (w_sum)
  );

`ifdef BOOT_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr_q;

  assign w_tmo = !readRX_q && (state_q != RUN) && (state_q != ERROR) &&
                 (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q <= '0;
    end else if (readRX_q || w_tmo || (state_q == RUN) || (state_q == ERROR)) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_tmo            = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // A pulse is never issued back to back, so charReady has a cycle to drop.
  assign readRX_d = charReady && !readRX_q && (state_q != RUN) && !w_tmo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      readRX_q  <= 1'b0;
      cpuHold_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      imAddr_q  <= BASE_A;
      cntHi_q   <= '0;
      words_q   <= '0;
    end else begin
      readRX_q <= readRX_d;
      if (w_wordValid) begin
        imAddr_q <= imAddr_q + ADDR_W'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (readRX_q && (RXchar == SYNC_BYTE)) begin
            state_q <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (readRX_q) begin
            cntHi_q <= RXchar;
            state_q <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (readRX_q) begin
            if (w_count == 16'd0) begin
              state_q <= CHK;
            end else if ({1'b0, w_count} > MAX_WORDS) begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end else begin
              state_q  <= DATA;
              words_q  <= w_count;
              imAddr_q <= BASE_A;
            end
          end
        end
        DATA: begin
          if (w_wordValid) begin
            words_q <= words_q - 16'd1;
            if (words_q == 16'd1) begin
              state_q <= CHK;
            end
          end
        end
        CHK: begin
          if (readRX_q) begin
            if (RXchar == w_sum) begin
              state_q   <= RUN;
              cpuHold_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        ERROR: begin
          if (readRX_q && (RXchar == SYNC_BYTE)) begin
            state_q <= CNT_HI;
            error_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Timeout never coincides with a consumed byte, so it cannot race the case above.
      if (w_tmo) begin
        if (state_q == IDLE) begin
          state_q   <= RUN;
          cpuHold_q <= 1'b0;
          done_q    <= 1'b1;
          error_q   <= 1'b0;
        end else begin
          state_q <= ERROR;
          error_q <= 1'b1;
        end
      end
    end
  end

  assign readRX  = readRX_q;
  assign imWe    = w_wordValid;
  assign imAddr  = imAddr_q;
  assign imData  = w_word;
  assign cpuHold = cpuHold_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// Module : tb_boot_loader
// Brief  : Directed self-checking bench for boot_loader (two instances for
//          BASE_ADDR=0 and BASE_ADDR=2047 address wrap).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       cr    = 1'b0;
  logic [7:0] rx    = 8'h00;
  logic       sel   = 1'b0;

  logic        rd_a, we_a, hold_a, dn_a, er_a;
  logic [10:0] addr_a;
  logic [31:0] data_a;
  logic        rd_b, we_b, hold_b, dn_b, er_b;
  logic [10:0] addr_b;
  logic [31:0] data_b;

  boot_loader #(
    .ADDR_W(11), .DATA_W(32), .BASE_ADDR(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)
  ) dut_a (
    .clock(clk), .reset_n(rst_n), .charReady(cr & ~sel), .RXchar(rx),
    .readRX(rd_a), .imWe(we_a), .imAddr(addr_a), .imData(data_a),
    .cpuHold(hold_a), .done(dn_a), .error(er_a)
  );

  boot_loader #(
    .ADDR_W(11), .DATA_W(32), .BASE_ADDR(2047), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .charReady(cr & sel), .RXchar(rx),
    .readRX(rd_b), .imWe(we_b), .imAddr(addr_b), .imData(data_b),
    .cpuHold(hold_b), .done(dn_b), .error(er_b)
  );

  logic        rd, we, hold, dn, er;
  logic [10:0] addr;
  logic [31:0] data;
  assign rd   = sel ? rd_b   : rd_a;
  assign we   = sel ? we_b   : we_a;
  assign hold = sel ? hold_b : hold_a;
  assign dn   = sel ? dn_b   : dn_a;
  assign er   = sel ? er_b   : er_a;
  assign addr = sel ? addr_b : addr_a;
  assign data = sel ? data_b : data_a;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write log and handshake monitor, sampled mid-cycle.
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          pulses = 0;
  int          viol   = 0;
  logic        rd_prev = 1'b0;

  always @(negedge clk) begin
    if (rd) pulses++;
    if (rd && (rd_prev || !cr)) viol++;
    rd_prev = rd;
    if (we) begin
      wa.push_back({21'd0, addr});
      wd.push_back(data);
    end
  end

  int w0 = 0;

  task automatic do_reset();
    rst_n = 1'b0;
    cr    = 1'b0;
    repeat (2) @(negedge clk);
    w0 = wa.size();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    bit got;
    got = 1'b0;
    rx  = b;
    cr  = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rd) got = 1'b1;
    end
    if (!got) check("rx_wait", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) cr = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input bit keep);
    foreach (q[i]) send_byte(q[i], keep && (i != q.size() - 1));
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] f_ok[$]  = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                           8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
  logic [7:0] f_bad[$] = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                           8'h55, 8'h66, 8'h77, 8'h88, 8'h89};
  logic [7:0] f_nil[$] = '{8'hA5, 8'h00, 8'h00, 8'h00};
  logic [7:0] f_junk[$] = '{8'h00, 8'hFF, 8'h5A};
  logic [7:0] f_big[$] = '{8'hA5, 8'h08, 8'h01};
  logic [7:0] f_part[$] = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int p0;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hold",  {31'd0, hold}, 32'd1);
    check("rst_done",  {31'd0, dn},   32'd0);
    check("rst_error", {31'd0, er},   32'd0);
    check("rst_readRX", {31'd0, rd},  32'd0);
    check("rst_imWe",  {31'd0, we},   32'd0);
    check("rst_addr",  {21'd0, addr}, 32'd0);
    check("rst_data",  data,          32'd0);
    do_reset();

    // Good two-word frame
    send_seq(f_ok, 1'b0);
    check("ok_nwr",   wa.size() - w0, 32'd2);
    check("ok_a0",    wa[w0],         32'd0);
    check("ok_d0",    wd[w0],         32'h11223344);
    check("ok_a1",    wa[w0 + 1],     32'd1);
    check("ok_d1",    wd[w0 + 1],     32'h55667788);
    check("ok_hold",  {31'd0, hold},  32'd0);
    check("ok_done",  {31'd0, dn},    32'd1);
    check("ok_error", {31'd0, er},    32'd0);
    p0 = pulses;
    rx = 8'hA5;
    cr = 1'b1;
    repeat (20) @(negedge clk);
    cr = 1'b0;
    check("run_no_read", pulses - p0, 32'd0);
    check("run_no_wr",   wa.size() - w0, 32'd2);

    // Bad checksum, then retry with empty image
    do_reset();
    send_seq(f_bad, 1'b0);
    check("bad_error", {31'd0, er},   32'd1);
    check("bad_hold",  {31'd0, hold}, 32'd1);
    check("bad_done",  {31'd0, dn},   32'd0);
    send_seq(f_nil, 1'b0);
    check("retry_done",  {31'd0, dn},   32'd1);
    check("retry_error", {31'd0, er},   32'd0);
    check("retry_hold",  {31'd0, hold}, 32'd0);

    // Leading junk, then a streamed frame with charReady held high
    do_reset();
    p0 = pulses;
    send_seq(f_junk, 1'b0);
    check("junk_pulses", pulses - p0, 32'd3);
    check("junk_done",   {31'd0, dn}, 32'd0);
    send_seq(f_ok, 1'b1);
    check("strm_nwr",  wa.size() - w0, 32'd2);
    check("strm_d1",   wd[w0 + 1],     32'h55667788);
    check("strm_done", {31'd0, dn},    32'd1);

    // Oversized count
    do_reset();
    send_seq(f_big, 1'b0);
    check("big_error", {31'd0, er},    32'd1);
    check("big_nwr",   wa.size() - w0, 32'd0);

    // Address wrap on the BASE_ADDR=2047 instance
    sel = 1'b1;
    do_reset();
    check("wrap_rst_addr", {21'd0, addr}, 32'd2047);
    send_seq(f_ok, 1'b0);
    check("wrap_a0",   wa[w0],     32'd2047);
    check("wrap_a1",   wa[w0 + 1], 32'd0);
    check("wrap_d1",   wd[w0 + 1], 32'h55667788);
    check("wrap_done", {31'd0, dn}, 32'd1);
    sel = 1'b0;

    // Reset in the middle of DATA, then a full load
    do_reset();
    send_seq(f_part, 1'b0);
    do_reset();
    check("mid_addr", {21'd0, addr}, 32'd0);
    send_seq(f_ok, 1'b0);
    check("mid_nwr",  wa.size() - w0, 32'd2);
    check("mid_a0",   wa[w0],         32'd0);
    check("mid_d0",   wd[w0],         32'h11223344);
    check("mid_done", {31'd0, dn},    32'd1);

`ifdef BOOT_TIMEOUT_EN
    do_reset();
    repeat (110) @(negedge clk);
    check("tmo_idle_done",  {31'd0, dn}, 32'd1);
    check("tmo_idle_error", {31'd0, er}, 32'd0);
    do_reset();
    send_seq(f_part, 1'b0);
    repeat (110) @(negedge clk);
    check("tmo_data_error", {31'd0, er},   32'd1);
    check("tmo_data_hold",  {31'd0, hold}, 32'd1);
`endif

    check("handshake_viol", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
